// File: rtl/sync_fifo_flagged.sv
// rtl/sync_fifo_flagged.sv - single-clock flagged FIFO with arbitrary depth and sticky error flags
module sync_fifo_flagged #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 8,
    parameter int AF_LEVEL   = 6,
    parameter int AE_LEVEL   = 2
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          w_inc_i,
    input  logic [DATA_WIDTH-1:0]         wr_data_i,
    input  logic                          r_inc_i,
    input  logic                          clr_err_i,
    output logic [DATA_WIDTH-1:0]         rd_data_o,
    output logic                          rd_valid_o,
    output logic                          full_o,
    output logic                          empty_o,
    output logic                          almost_full_o,
    output logic                          almost_empty_o,
    output logic [$clog2(DEPTH+1)-1:0]    count_o,
    output logic                          overflow_o,
    output logic                          underflow_o
);

    localparam int CNT_WIDTH = $clog2(DEPTH + 1);
    localparam int PTR_WIDTH = $clog2(DEPTH);

    localparam logic [PTR_WIDTH-1:0] PTR_LAST = PTR_WIDTH'(DEPTH - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_FULL = CNT_WIDTH'(DEPTH);
    localparam logic [CNT_WIDTH-1:0] CNT_AF   = CNT_WIDTH'(AF_LEVEL);
    localparam logic [CNT_WIDTH-1:0] CNT_AE   = CNT_WIDTH'(AE_LEVEL);

    // Storage; deliberately not reset so it can map onto plain RAM.
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic [PTR_WIDTH-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_WIDTH-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_WIDTH-1:0]  count_q, count_d;
    logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
    logic                  rd_valid_q, rd_valid_d;
    logic                  full_q, full_d;
    logic                  empty_q, empty_d;
    logic                  af_q, af_d;
    logic                  ae_q, ae_d;
    logic                  ovf_q, ovf_d;
    logic                  unf_q, unf_d;

    logic                  wr_en;
    logic                  rd_en;

    // Accept decisions use the registered flags from the start of the cycle,
    // so a full FIFO still accepts a read and an empty one still accepts a write.
    assign wr_en = w_inc_i & ~full_q;
    assign rd_en = r_inc_i & ~empty_q;

    // Next-state pointers, count, read data and status flags.
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = 1'b0;

        // Pointers wrap explicitly at DEPTH-1 because DEPTH need not be 2^n.
        if (wr_en) begin
            wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PTR_WIDTH'(1);
        end
        if (rd_en) begin
            rd_ptr_d   = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + PTR_WIDTH'(1);
            rd_data_d  = mem_q[rd_ptr_q];
            rd_valid_d = 1'b1;
        end

        unique case ({wr_en, rd_en})
            2'b10:   count_d = count_q + CNT_WIDTH'(1);
            2'b01:   count_d = count_q - CNT_WIDTH'(1);
            default: count_d = count_q;
        endcase

        // Flags decoded from the next count so they are exact one cycle later.
        full_d  = (count_d == CNT_FULL);
        empty_d = (count_d == '0);
        af_d    = (count_d >= CNT_AF);
        ae_d    = (count_d <= CNT_AE);

        // Sticky errors: a new error in the same cycle as a clear keeps the flag set.
        ovf_d = (ovf_q & ~clr_err_i) | (w_inc_i & full_q);
        unf_d = (unf_q & ~clr_err_i) | (r_inc_i & empty_q);
    end

    // Control and status registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            full_q     <= 1'b0;
            empty_q    <= 1'b1;
            af_q       <= 1'b0;
            ae_q       <= 1'b1;
            ovf_q      <= 1'b0;
            unf_q      <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            full_q     <= full_d;
            empty_q    <= empty_d;
            af_q       <= af_d;
            ae_q       <= ae_d;
            ovf_q      <= ovf_d;
            unf_q      <= unf_d;
        end
    end

    // Memory write port; reset blocks writes but does not clear contents.
    always_ff @(posedge clk_i) begin
        if (!rst_i && wr_en) begin
            mem_q[wr_ptr_q] <= wr_data_i;
        end
    end

    assign rd_data_o      = rd_data_q;
    assign rd_valid_o     = rd_valid_q;
    assign full_o         = full_q;
    assign empty_o        = empty_q;
    assign almost_full_o  = af_q;
    assign almost_empty_o = ae_q;
    assign count_o        = count_q;
    assign overflow_o     = ovf_q;
    assign underflow_o    = unf_q;

endmodule
